// File: rtl/gmii_frame_checker_if.sv
// GMII receive byte stream: the link source drives it, the frame checker samples it.
interface gmii_frame_checker_if;
    logic [7:0] rxd;
    logic       rx_dv;
    logic       rx_er;

    modport master (output rxd, output rx_dv, output rx_er);
    modport slave  (input  rxd, input  rx_dv, input  rx_er);
endinterface

// File: rtl/gmii_frame_checker.sv
// GMII receive frame checker: preamble/SFD detect, FCS + length check, saturating stats.
// Latency: frame_done/frame_ok/frame_len registered 1 cycle after rx_dv falls.
// Backpressure: none, GMII cannot stall. Optional synchronous counter clear: GMII_FRAME_CHECKER_CLEAR_EN.
module gmii_frame_checker #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
`ifdef GMII_FRAME_CHECKER_CLEAR_EN
    input  logic                 clear,
`endif
    gmii_frame_checker_if.slave  gmii_in,
    output logic                 frame_done,
    output logic                 frame_ok,
    output logic [15:0]          frame_len,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] good_cnt,
    output logic [CNT_WIDTH-1:0] crc_err_cnt,
    output logic [CNT_WIDTH-1:0] len_err_cnt,
    output logic [CNT_WIDTH-1:0] gmii_err_cnt,
    output logic [CNT_WIDTH-1:0] byte_cnt
);

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
    localparam logic [15:0] MIN_LEN       = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_LEN       = 16'(MAX_FRAME);
    localparam int          N_CNT         = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   sfd_hit, data_byte, eof;

    logic [31:0] crc_q;
    logic [15:0] len_q;
    logic        gmii_err_q;
    logic        oversize_q;

    logic crc_ok, len_ok, frame_ok_d, crc_err_d;
    logic clr;

    logic [N_CNT-1:0]     cnt_inc;
    logic [CNT_WIDTH-1:0] cnt_q [N_CNT];

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        sfd_hit   = 1'b0;
        data_byte = 1'b0;
        eof       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gmii_in.rx_dv) begin
                    state_d = (gmii_in.rxd == PREAMBLE_BYTE) ? PREAMBLE : DROP;
                end
            end
            PREAMBLE: begin
                if (!gmii_in.rx_dv) begin
                    state_d = IDLE;
                end else if (gmii_in.rxd == SFD_BYTE) begin
                    state_d = DATA;
                    sfd_hit = 1'b1;
                end else if (gmii_in.rxd != PREAMBLE_BYTE) begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (gmii_in.rx_dv) begin
                    data_byte = 1'b1;
                end else begin
                    state_d = IDLE;
                    eof     = 1'b1;
                end
            end
            DROP: begin
                if (!gmii_in.rx_dv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Oversize is sticky so a saturated length counter can never look legal.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crc_q      <= CRC_INIT;
            len_q      <= 16'd0;
            gmii_err_q <= 1'b0;
            oversize_q <= 1'b0;
        end else if (sfd_hit) begin
            crc_q      <= CRC_INIT;
            len_q      <= 16'd0;
            gmii_err_q <= 1'b0;
            oversize_q <= 1'b0;
        end else if (data_byte) begin
            crc_q <= crc32_byte(crc_q, gmii_in.rxd);
            if (len_q != 16'hFFFF) len_q <= len_q + 16'd1;
            if (len_q >= MAX_LEN)  oversize_q <= 1'b1;
            if (gmii_in.rx_er)     gmii_err_q <= 1'b1;
        end
    end

    assign crc_ok     = (crc_q == CRC_RESIDUE);
    assign len_ok     = (len_q >= MIN_LEN) && !oversize_q;
    assign frame_ok_d = crc_ok && len_ok && !gmii_err_q;
    // A frame shorter than the FCS itself is a length error only.
    assign crc_err_d  = !crc_ok && (len_q >= 16'd4);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_len  <= 16'd0;
        end else begin
            frame_done <= eof;
            if (eof) begin
                frame_ok  <= frame_ok_d;
                frame_len <= len_q;
            end
        end
    end

`ifdef GMII_FRAME_CHECKER_CLEAR_EN
    assign clr = clear;
`else
    assign clr = 1'b0;
`endif

    assign cnt_inc = {data_byte,
                      eof && gmii_err_q,
                      eof && !len_ok,
                      eof && crc_err_d,
                      eof && frame_ok_d,
                      sfd_hit};

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_CNT; i++) cnt_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < N_CNT; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_CNT; i++) begin
                if (cnt_inc[i] && (cnt_q[i] != {CNT_WIDTH{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign frame_cnt    = cnt_q[0];
    assign good_cnt     = cnt_q[1];
    assign crc_err_cnt  = cnt_q[2];
    assign len_err_cnt  = cnt_q[3];
    assign gmii_err_cnt = cnt_q[4];
    assign byte_cnt     = cnt_q[5];

endmodule
